ntlm_target_loader: RTL
=======================

Name: ntlm_target_loader

Overview:
- Upstream neighbour of the hash comparator.
- Accepts target NTLM hashes one at a time over a valid/ready stream.
- Assembles them into the flat 64×128-bit target table that the comparator reads.
- Pads unloaded slots so the comparator never reports a spurious index, and flags when the table is locked and usable.

Parameters:
- NUM_HASHES, 64, number of table slots; fixed to match the comparator's 64-entry priority search.
- HASH_W, 128, bits per NTLM hash.

Ports:
- clk  input  1  system clock
- n_rst  input  1  asynchronous active-low reset
- clear  input  1  synchronous table wipe; returns block to EMPTY
- hash_in  input  [0:127]  target hash; bit 0 is MSB, same orientation as the comparator's hash inputs
- hash_valid  input  1  hash_in is presented this cycle
- hash_last  input  1  qualifies hash_in as the final target; sampled only on an accepted transfer
- hash_ready  output  1  block can accept a hash this cycle
- hashes  output  [0:8191]  flat target table; slot k occupies bits [k*128 : k*128+127]; feeds the comparator
- count  output  7  number of hashes loaded, 0..64
- table_valid  output  1  table is locked and may be searched
- overflow_err  output  1  sticky; a hash was offered while LOCKED

Behaviour:
- Reset (n_rst low, asynchronous):
  - hashes = all zeros, count = 0, table_valid = 0, overflow_err = 0.
  - State = EMPTY, hash_ready = 0 during reset.
  - Reset mid-load discards all partial contents.
- States: EMPTY, LOADING, LOCKED. hash_ready = 1 in EMPTY and LOADING, 0 in LOCKED.
- Transfer rule:
  - A transfer occurs on a rising edge where hash_valid & hash_ready.
  - hash_ready does not depend combinationally on hash_valid.
- Write on accept, with count = k before the edge:
  - Slots k..63 are all written with hash_in. Earlier slots are unchanged.
  - count becomes k+1.
  - Effect: unloaded slots always duplicate the last loaded hash. The comparator's lowest-index priority then returns the genuine index k, never a padded slot.
- Transitions:
  - EMPTY, on accept: LOADING if hash_last = 0 and count becomes < 64; otherwise LOCKED.
  - LOADING, on accept: LOCKED if hash_last = 1 or count becomes 64; otherwise stay in LOADING.
  - LOCKED: only leaves on clear.
- table_valid:
  - Registered; = 1 exactly while in LOCKED.
  - Asserts on the cycle after the final accepting edge, together with the final hashes/count values.
- Overflow:
  - hash_valid = 1 while LOCKED sets overflow_err on the next edge.
  - The table is unchanged. overflow_err holds until clear or reset.
- clear (synchronous, highest priority):
  - On an edge with clear = 1: hashes = 0, count = 0, table_valid = 0, overflow_err = 0, state = EMPTY.
  - Any simultaneous transfer is dropped.
- Latency: one cycle from an accepting edge to the updated hashes/count. No combinational path from hash_in to hashes.
- Empty table: with count = 0 and table_valid = 0, downstream must ignore comparator output. The table is all zeros.
- Boundary cases:
  - The 64th accept forces LOCKED regardless of hash_last.
  - hash_last on the first accept gives a one-entry table, with all 64 slots equal to that hash.
- Implementation: the write-enable per slot is (slot_index >= count) & accept, one 128-bit register per slot. count is 7 bits and saturates at 64 by construction, since ready is low in LOCKED.

Test Plan:
- Reset, then 3 accepts (H0 = 0x…01, H1 = 0x…02, H2 = 0x…03, last on H2):
  - Slots 0/1/2 hold H0/H1/H2; slots 3..63 = H2; count = 3.
  - table_valid = 1 the cycle after the third accept; hash_ready = 0.
- Stream 64 distinct hashes (slot k value = k+1) with hash_last never set:
  - Auto-LOCK after the 64th; count = 64; slot 63 = 64; table_valid = 1.
- In LOCKED, drive hash_valid = 1 for 1 cycle with H = 0xDEAD…:
  - overflow_err = 1 the next cycle and stays 1; table unchanged; count unchanged.
- Backpressure/idle: valid toggled 1,0,0,1 with distinct hashes:
  - Exactly 2 entries stored; count = 2; no writes on idle cycles.
- clear asserted on the same edge as a valid transfer during LOADING (count = 5):
  - Next cycle count = 0, hashes = 0, state EMPTY, overflow_err = 0; the dropped hash is not stored.
- n_rst pulsed low asynchronously mid-cycle during LOADING (count = 10):
  - Outputs go to reset values immediately, without waiting for clk.
  - After release, the first accept writes slot 0.

Source files
------------

// File: rtl/ntlm_target_loader.sv
// Target-hash loader: assembles streamed NTLM hashes into the flat table read by the
// comparator, padding unloaded slots with the most recent hash.
module ntlm_target_loader #(
    parameter int unsigned NUM_HASHES = 64,
    parameter int unsigned HASH_W     = 128,
    localparam int unsigned CntW      = $clog2(NUM_HASHES + 1)
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic                          clear,
    input  logic [0:HASH_W-1]             hash_in,
    input  logic                          hash_valid,
    input  logic                          hash_last,
    output logic                          hash_ready,
    output logic [0:NUM_HASHES*HASH_W-1]  hashes,
    output logic [CntW-1:0]               count,
    output logic                          table_valid,
    output logic                          overflow_err
);

    typedef enum logic [1:0] {StEmpty, StLoading, StLocked} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   count_q, count_d, count_inc;
    logic              ovf_q, ovf_d;
    logic [0:HASH_W-1] slot_q [NUM_HASHES];
    logic [0:HASH_W-1] slot_d [NUM_HASHES];
    logic              accept;

    assign hash_ready = n_rst & (state_q != StLocked);
    assign accept     = hash_valid & hash_ready;
    assign count_inc  = count_q + CntW'(1);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        slot_d  = slot_q;
        if (clear) begin
            state_d = StEmpty;
            count_d = '0;
            ovf_d   = 1'b0;
            for (int i = 0; i < NUM_HASHES; i++) begin
                slot_d[i] = '0;
            end
        end else begin
            if ((state_q == StLocked) && hash_valid) begin
                ovf_d = 1'b1;
            end
            if (accept) begin
                count_d = count_inc;
                // Fill this slot and every later one so padding mirrors the newest hash.
                for (int i = 0; i < NUM_HASHES; i++) begin
                    if (CntW'(i) >= count_q) begin
                        slot_d[i] = hash_in;
                    end
                end
                if (hash_last || (count_inc == CntW'(NUM_HASHES))) begin
                    state_d = StLocked;
                end else begin
                    state_d = StLoading;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= StEmpty;
            count_q <= '0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < NUM_HASHES; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            for (int i = 0; i < NUM_HASHES; i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

    for (genvar k = 0; k < NUM_HASHES; k++) begin : g_flat
        assign hashes[k*HASH_W +: HASH_W] = slot_q[k];
    end

    assign count        = count_q;
    assign table_valid  = (state_q == StLocked);
    assign overflow_err = ovf_q;

endmodule
